// File: rtl/drum_mul_share.sv
// Shared DRUM5 approximate 16x16 multiplier with round-robin arbitration among NREQ requesters.
// Two registered stages: S1 holds the accepted operands, S2 holds the product handed to the consumer.
module drum_mul_share #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_r,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy,
    output logic [31:0]          op_count
);

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     s1_a_q, s1_a_d;
    logic [15:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_r_q, resp_r_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [31:0]     op_count_q, op_count_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            s2_load, s1_adv, accept_en, accept;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    int              idx;
    logic [8:0]      split_a, split_b;
    logic [9:0]      mant_prod;
    logic [4:0]      shift_sum;
    logic [31:0]     core_r;

    // Returns {shift[3:0], mantissa[4:0]}; operands below 32 pass through exactly.
    function automatic logic [8:0] drum_split(input logic [15:0] x);
        logic [3:0]  k;
        logic [15:0] t;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) k = 4'(i);
        end
        if (k <= 4'd4) begin
            return {4'd0, x[4:0]};
        end
        t = x >> (k - 4'd4);
        return {k - 4'd4, t[4:1], 1'b1};
    endfunction

    assign s2_load   = !resp_valid_q | resp_ready;
    assign s1_adv    = s1_valid_q & s2_load;
    assign accept_en = !s1_valid_q | s1_adv;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int j = 1; j <= NREQ; j++) begin
            idx = (int'(rr_ptr_q) + j) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[IDW-1:0];
            end
        end
    end

    assign accept    = accept_en & gnt_found & rst_n;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    assign split_a   = drum_split(s1_a_q);
    assign split_b   = drum_split(s1_b_q);
    assign mant_prod = split_a[4:0] * split_b[4:0];
    assign shift_sum = {1'b0, split_a[8:5]} + {1'b0, split_b[8:5]};
    assign core_r    = {22'd0, mant_prod} << shift_sum;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        resp_valid_d = resp_valid_q;
        resp_r_d     = resp_r_q;
        resp_id_d    = resp_id_q;
        rr_ptr_d     = rr_ptr_q;
        op_count_d   = op_count_q + 32'(resp_valid_q & resp_ready);

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[16*gnt_idx +: 16];
            s1_b_d     = req_b[16*gnt_idx +: 16];
            s1_id_d    = gnt_idx;
            rr_ptr_d   = gnt_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            resp_valid_d = 1'b1;
            resp_r_d     = core_r;
            resp_id_d    = s1_id_q;
        end else if (s2_load) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_r_q     <= '0;
            resp_id_q    <= '0;
            op_count_q   <= '0;
            rr_ptr_q     <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_r_q     <= resp_r_d;
            resp_id_q    <= resp_id_d;
            op_count_q   <= op_count_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_r     = resp_r_q;
    assign resp_id    = resp_id_q;
    assign busy       = s1_valid_q | resp_valid_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_drum_mul_share.sv
// Bench for drum_mul_share: directed scenarios plus random traffic, all checked against
// an arithmetic DRUM5 reference and a queue model of the two-slot pipeline.
module tb_drum_mul_share;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_a = '0;
    logic [16*NREQ-1:0]  req_b = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [31:0]         resp_r;
    logic [IDW-1:0]      resp_id;
    logic                busy;
    logic [31:0]         op_count;

    drum_mul_share #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_r(resp_r), .resp_id(resp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        int          id;
    } item_t;

    item_t        s1_q[$];
    item_t        out_q[$];
    int           rr;
    logic [31:0]  m_count;
    int           n_checks = 0;
    int           n_errors = 0;

    bit           pv[NREQ];
    logic [15:0]  pa[NREQ];
    logic [15:0]  pb[NREQ];
    int           last_grant;
    logic [NREQ-1:0] last_rdy;
    logic         last_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void split(input int unsigned x, output int unsigned m, output int unsigned s);
        int k = -1;
        for (int i = 0; i < 16; i++) if (x >= (32'd1 << i)) k = i;
        if (k <= 4) begin
            m = x;
            s = 0;
        end else begin
            s = k - 4;
            m = (x >> s) | 1;
        end
    endfunction

    function automatic logic [31:0] drum_ref(input int unsigned a, input int unsigned b);
        int unsigned ma, mb, sa, sb;
        split(a, ma, sa);
        split(b, mb, sb);
        return (ma * mb) << (sa + sb);
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pv[i];
            req_a[16*i +: 16]  = pa[i];
            req_b[16*i +: 16]  = pb[i];
        end
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 31));
            1: return 16'd0;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: compare outputs with the model, then advance the model across the edge.
    task automatic cycle();
        bit          en;
        int          g;
        logic [15:0] ga, gb;
        #1;
        en = rst_n && (s1_q.size() == 0 || out_q.size() == 0 || resp_ready);
        g = -1;
        if (en) begin
            for (int j = 1; j <= NREQ; j++) begin
                int i = (rr + j) % NREQ;
                if (g < 0 && pv[i]) g = i;
            end
        end
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("resp_valid", 32'(resp_valid), 32'(out_q.size() > 0));
        if (out_q.size() > 0) begin
            chk("resp_r", resp_r, out_q[0].r);
            chk("resp_id", 32'(resp_id), 32'(out_q[0].id));
        end
        chk("busy", 32'(busy), 32'(s1_q.size() + out_q.size() > 0));
        chk("op_count", op_count, m_count);
        last_grant = g;
        last_rdy   = req_ready;
        last_fire  = resp_valid & resp_ready;
        if (g >= 0) begin
            ga = pa[g];
            gb = pb[g];
        end else begin
            ga = '0;
            gb = '0;
        end
        @(posedge clk);
        if (out_q.size() > 0 && resp_ready) begin
            void'(out_q.pop_front());
            m_count++;
        end
        if (s1_q.size() > 0 && out_q.size() == 0) out_q.push_back(s1_q.pop_front());
        if (g >= 0) begin
            item_t it;
            it.r  = drum_ref(ga, gb);
            it.id = g;
            s1_q.push_back(it);
            rr = g;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        s1_q.delete();
        out_q.delete();
        rr = NREQ - 1;
        m_count = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_one(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_r);
        bit accepted = 0;
        bit seen = 0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        pv[id] = 1'b1;
        pa[id] = a;
        pb[id] = b;
        resp_ready = 1'b1;
        drive();
        for (int t = 0; t < 10 && !accepted; t++) begin
            cycle();
            if (last_grant == id) begin
                accepted = 1;
                chk("grant_rdy", 32'(last_rdy), 32'd1 << id);
            end
        end
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        pv[id] = 1'b0;
        drive();
        for (int t = 0; t < 10 && !seen; t++) begin
            #1;
            if (resp_valid) begin
                chk("drum_r", resp_r, exp_r);
                chk("drum_id", 32'(resp_id), 32'(id));
                seen = 1;
            end
            cycle();
        end
        if (!seen) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        resp_ready = 1'b1;
        drive();
        repeat (3) cycle();
    endtask

    initial begin
        int accepts;
        int fires;
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", op_count, 32'd0);

        // Exact range, then the approximated and zero cases.
        send_one(1, 16'd13, 16'd11, 32'd143);
        chk("count_after_one", op_count, 32'd1);
        send_one(0, 16'd1000, 16'd3, 32'd2976);
        send_one(3, 16'hFFFF, 16'hFFFF, 32'd4030726144);
        send_one(2, 16'd0, 16'h1234, 32'd0);

        // Round robin from reset with all requesters asserted.
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1;
            pa[i] = 16'(100 + i);
            pb[i] = 16'(7 * i + 3);
        end
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_grant", 32'(last_rdy), 32'd1 << (k % NREQ));
            if (last_grant >= 0) begin
                pa[last_grant] = rand_op();
                pb[last_grant] = rand_op();
            end
            drive();
        end
        drain();

        // Backpressure with requester 2 streaming.
        resp_ready = 1'b0;
        pv[2] = 1'b1;
        pa[2] = 16'd500;
        pb[2] = 16'd77;
        drive();
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (last_rdy[2]) begin
                accepts++;
                pa[2] = rand_op();
                pb[2] = rand_op();
                drive();
            end
        end
        chk("bp_accepts", 32'(accepts), 32'd2);
        #1;
        chk("bp_stalled_rdy", 32'(req_ready), 32'd0);
        pv[2] = 1'b0;
        resp_ready = 1'b1;
        drive();
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (last_fire) fires++;
        end
        chk("bp_drain", 32'(fires), 32'd2);

        // Reset with both stages full.
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b1;
        drive();
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        resp_ready = 1'b1;
        cycle();
        chk("post_rst_grant", 32'(last_rdy), 32'd1);
        chk("post_rst_count", op_count, 32'd0);
        drain();

        // Counter wrap through a backdoor preset.
        resp_ready = 1'b0;
        force dut.op_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.op_count_q;
        m_count = 32'hFFFF_FFFE;
        @(negedge clk);
        send_one(1, 16'd5, 16'd6, 32'd30);
        chk("wrap_ffffffff", op_count, 32'hFFFF_FFFF);
        send_one(2, 16'd40, 16'd40, drum_ref(40, 40));
        chk("wrap_zero", op_count, 32'd0);

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = rand_op();
                    pb[i] = rand_op();
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            drive();
            cycle();
            if (last_grant >= 0) pv[last_grant] = 1'b0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
